// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed, XOR-checksummed program byte stream,
// writes it word by word into instruction memory and, once the checksum
// matches, releases the CPU from reset and starts it. Any framing error parks
// the block in ERR with the CPU held in reset.
module boot_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        cpu_rst_n_o,
  output logic        start_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] words_o
);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_RUN    = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  // Running frame checksum: XOR of every byte seen so far.
  function automatic logic [7:0] csum_upd(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

  state_e      state_q;
  logic [7:0]  len_hi_q;
  logic [15:0] words_q;
  logic [7:0]  csum_q;
  logic [23:0] asm_q;       // first three bytes of the word being assembled
  logic [1:0]  byte_cnt_q;  // byte position inside the current word
  logic [15:0] idx_q;       // index of the next word to write
  logic        imem_we_q;
  logic [31:0] imem_addr_q;
  logic [31:0] imem_wdata_q;
  logic        cpu_rst_n_q;
  logic        start_q;
  logic        done_q;
  logic        err_q;

  logic        rx_ready_s;
  logic        accept_s;
  logic [15:0] len_d;
  logic [31:0] word_d;
  logic [31:0] addr_d;
  logic        len_over_s;
  logic        last_word_s;

  // Byte intake is open in every state that still expects frame bytes.
  assign rx_ready_s  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                       (state_q == S_DATA)   || (state_q == S_CSUM);
  assign accept_s    = rx_valid_i && rx_ready_s;
  assign len_d       = {len_hi_q, rx_data_i};
  assign word_d      = {asm_q, rx_data_i};
  assign addr_d      = BASE_ADDR + {14'd0, idx_q, 2'b00};
  assign len_over_s  = ({1'b0, len_d} > DEPTH_W);
  assign last_word_s = ((idx_q + 16'd1) == words_q);

  // Frame FSM with registered memory-write and CPU-control outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_LEN_HI;
      len_hi_q     <= 8'h00;
      words_q      <= 16'h0000;
      csum_q       <= 8'h00;
      asm_q        <= 24'h00_0000;
      byte_cnt_q   <= 2'd0;
      idx_q        <= 16'h0000;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 32'h0000_0000;
      imem_wdata_q <= 32'h0000_0000;
      cpu_rst_n_q  <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      imem_we_q <= 1'b0;
      case (state_q)
        S_LEN_HI: begin
          if (accept_s) begin
            len_hi_q <= rx_data_i;
            csum_q   <= csum_upd(csum_q, rx_data_i);
            state_q  <= S_LEN_LO;
          end else begin
            state_q  <= S_LEN_HI;
          end
        end
        S_LEN_LO: begin
          if (accept_s) begin
            words_q <= len_d;
            csum_q  <= csum_upd(csum_q, rx_data_i);
            if (len_over_s) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else if (len_d == 16'h0000) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            state_q <= S_LEN_LO;
          end
        end
        S_DATA: begin
          if (accept_s) begin
            csum_q <= csum_upd(csum_q, rx_data_i);
            if (byte_cnt_q == 2'd3) begin
              // Word complete: present it to memory on the following cycle.
              imem_we_q    <= 1'b1;
              imem_wdata_q <= word_d;
              imem_addr_q  <= addr_d;
              idx_q        <= idx_q + 16'd1;
              byte_cnt_q   <= 2'd0;
              asm_q        <= 24'h00_0000;
              if (last_word_s) begin
                state_q <= S_CSUM;
              end else begin
                state_q <= S_DATA;
              end
            end else begin
              asm_q      <= {asm_q[15:0], rx_data_i};
              byte_cnt_q <= byte_cnt_q + 2'd1;
              state_q    <= S_DATA;
            end
          end else begin
            state_q <= S_DATA;
          end
        end
        S_CSUM: begin
          if (accept_s) begin
            if (rx_data_i == csum_q) begin
              // Release and start the CPU in the same cycle.
              state_q     <= S_RUN;
              cpu_rst_n_q <= 1'b1;
              start_q     <= 1'b1;
              done_q      <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end else begin
            state_q <= S_CSUM;
          end
        end
        S_RUN: begin
          state_q <= S_RUN;
        end
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: begin
          // Unreachable encoding: fail safe with the CPU held in reset.
          state_q     <= S_ERR;
          err_q       <= 1'b1;
          cpu_rst_n_q <= 1'b0;
          start_q     <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready_o   = rx_ready_s;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_rst_n_o  = cpu_rst_n_q;
  assign start_o      = start_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign words_o      = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: expected memory writes are queued as
// bytes are driven and compared as the DUT emits write strobes.
module tb_boot_loader;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        start;
  logic        done;
  logic        err;
  logic [15:0] words;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          wr_cnt   = 0;
  logic [7:0]  tb_csum;
  logic [63:0] exp_q [$];

  boot_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .rx_ready_o   (rx_ready),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .cpu_rst_n_o  (cpu_rst_n),
    .start_o      (start),
    .done_o       (done),
    .err_o        (err),
    .words_o      (words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [63:0] e;
    if (imem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", {31'd0, imem_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_addr", imem_addr, e[63:32]);
        check_eq("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic apply_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    tb_csum  = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    g = gaps ? int'($urandom_range(3, 0)) : 0;
    rx_valid = 1'b0;
    repeat (g) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    tb_csum  = tb_csum ^ b;
  endtask

  task automatic send_len(input logic [15:0] n, input bit gaps);
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
  endtask

  task automatic send_word(input logic [31:0] w, input int idx, input bit gaps);
    logic [31:0] a;
    a = 32'(idx) * 32'd4;
    exp_q.push_back({a, w});
    send_byte(w[31:24], gaps);
    send_byte(w[23:16], gaps);
    send_byte(w[15:8], gaps);
    send_byte(w[7:0], gaps);
  endtask

  task automatic send_csum(input logic [7:0] flip, input bit gaps);
    check_eq("pre_csum_start", {31'd0, start}, 32'd0);
    send_byte(tb_csum ^ flip, gaps);
  endtask

  task automatic check_run(input string tag, input logic [15:0] n);
    check_eq({tag, "_start"}, {31'd0, start}, 32'd1);
    check_eq({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd1);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    check_eq({tag, "_err"}, {31'd0, err}, 32'd0);
    check_eq({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check_eq({tag, "_words"}, {16'd0, words}, {16'd0, n});
  endtask

  task automatic check_err(input string tag);
    check_eq({tag, "_err"}, {31'd0, err}, 32'd1);
    check_eq({tag, "_start"}, {31'd0, start}, 32'd0);
    check_eq({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
    check_eq({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    check_eq({tag, "_start"}, {31'd0, start}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, err}, 32'd0);
    check_eq({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    check_eq({tag, "_words"}, {16'd0, words}, 32'd0);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tb_csum  = 8'h00;

    // 1: back-to-back two-word frame.
    apply_reset();
    check_idle("rst1");
    send_len(16'd2, 1'b0);
    send_word(32'h2001_0005, 0, 1'b0);
    send_word(32'h0022_1020, 1, 1'b0);
    send_csum(8'h00, 1'b0);
    check_run("t1", 16'd2);
    drain("t1");
    check_eq("t1_addr_hold", imem_addr, 32'h0000_0004);
    check_eq("t1_data_hold", imem_wdata, 32'h0022_1020);
    check_eq("t1_wr_cnt", 32'(wr_cnt), 32'd2);

    // 2: same frame with random idle gaps.
    apply_reset();
    send_len(16'd2, 1'b1);
    send_word(32'h2001_0005, 0, 1'b1);
    send_word(32'h0022_1020, 1, 1'b1);
    send_csum(8'h00, 1'b1);
    check_run("t2", 16'd2);
    drain("t2");

    // 3: corrupted checksum; later bytes must be ignored.
    apply_reset();
    send_len(16'd2, 1'b0);
    send_word(32'h2001_0005, 0, 1'b0);
    send_word(32'h0022_1020, 1, 1'b0);
    send_csum(8'h01, 1'b0);
    check_err("t3");
    w0 = wr_cnt;
    for (int i = 0; i < 6; i++) send_byte(8'(i * 37), 1'b0);
    drain("t3");
    check_eq("t3_no_writes", 32'(wr_cnt - w0), 32'd0);
    check_eq("t3_still_err", {31'd0, err}, 32'd1);

    // 4: oversize length 257.
    apply_reset();
    w0 = wr_cnt;
    send_len(16'h0101, 1'b0);
    check_err("t4");
    check_eq("t4_words", {16'd0, words}, 32'h0000_0101);
    for (int i = 0; i < 8; i++) send_byte(8'hA5, 1'b0);
    drain("t4");
    check_eq("t4_no_writes", 32'(wr_cnt - w0), 32'd0);

    // 5: empty program.
    apply_reset();
    w0 = wr_cnt;
    send_len(16'd0, 1'b0);
    send_csum(8'h00, 1'b0);
    check_run("t5", 16'd0);
    drain("t5");
    check_eq("t5_no_writes", 32'(wr_cnt - w0), 32'd0);

    // 6: reset mid-frame, then a fresh frame starting at address 0.
    apply_reset();
    send_len(16'd2, 1'b0);
    send_word(32'h1111_2222, 0, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    drain("t6a");
    apply_reset();
    check_idle("rst6");
    send_len(16'd2, 1'b0);
    send_word(32'hDEAD_BEEF, 0, 1'b0);
    send_word(32'h1234_5678, 1, 1'b0);
    send_csum(8'h00, 1'b0);
    check_run("t6", 16'd2);
    drain("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
